// File: rtl/hazard_stall_controller.sv
// Decode-stage hazard and stall controller: load-use, branch-operand and multiply-freeze sequencing.
// Optional performance counter enabled by defining HAZARD_PERF_CNT_EN.
module hazard_stall_controller #(
  parameter int unsigned MUL_LATENCY = 4,
  parameter int unsigned REG_ADDR_W  = 5
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  input  logic                  id_is_branch,
  input  logic                  id_take,
  input  logic                  id_mul,
  input  logic                  ex_RegWrite,
  input  logic                  ex_MemRead,
  input  logic [REG_ADDR_W-1:0] ex_dst,
  input  logic                  mem_MemRead,
  input  logic [REG_ADDR_W-1:0] mem_dst,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  ifid_flush,
  output logic                  idex_bubble,
  output logic                  redirect_en,
  output logic                  mul_busy,
  output logic [15:0]           stall_cycles
);

  typedef enum logic [0:0] {StRun, StMulWait} state_e;

  localparam int unsigned CntW      = 4;
  localparam logic [CntW-1:0] MulLoad = CntW'(MUL_LATENCY - 1);
  localparam bit MulFreeze = (MUL_LATENCY > 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Register $0 is hardwired to zero, so it can never carry a dependency.
  function automatic logic match(input logic [REG_ADDR_W-1:0] a, input logic [REG_ADDR_W-1:0] d);
    return (d != '0) && (a == d);
  endfunction

  function automatic logic src_hit(input logic [REG_ADDR_W-1:0] d);
    return match(id_rs, d) || (id_uses_rt && match(id_rt, d));
  endfunction

  logic load_use, br_ex, br_mem, data_stall;

  always_comb begin
    load_use   = id_valid && ex_MemRead && src_hit(ex_dst);
    br_ex      = id_valid && id_is_branch && ex_RegWrite && src_hit(ex_dst);
    br_mem     = id_valid && id_is_branch && mem_MemRead && src_hit(mem_dst);
    data_stall = load_use || br_ex || br_mem;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    redirect_en = 1'b0;
    mul_busy    = 1'b0;
    unique case (state_q)
      StRun: begin
        if (data_stall) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
        end else begin
          if (id_valid && id_take) begin
            redirect_en = 1'b1;
            ifid_flush  = 1'b1;
          end
          // The multiply itself proceeds into EX; only younger instructions freeze.
          if (id_valid && id_mul && MulFreeze) begin
            cnt_d   = MulLoad;
            state_d = StMulWait;
          end
        end
      end
      StMulWait: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
        mul_busy    = 1'b1;
        cnt_d       = cnt_q - 1'b1;
        if (cnt_q == CntW'(1)) begin
          state_d = StRun;
        end
      end
      default: begin
        state_d = StRun;
        cnt_d   = '0;
      end
    endcase
    // Outputs take their idle values for as long as reset is held.
    if (!Reset) begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      redirect_en = 1'b0;
      mul_busy    = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= StRun;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (!pc_write && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Self-checking bench for hazard_stall_controller: vector table, hand sequences, random vs model.
module tb_hazard_stall_controller;

  localparam int unsigned MulLat = 4;
  localparam int unsigned AW     = 5;

  typedef struct {
    logic          valid;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic          uses_rt;
    logic          br;
    logic          take;
    logic          mul;
    logic          ex_rw;
    logic          ex_mr;
    logic [AW-1:0] ex_dst;
    logic          mem_mr;
    logic [AW-1:0] mem_dst;
  } in_t;

  typedef struct {
    string      name;
    in_t        in;
    logic [5:0] exp;  // {pc_write, ifid_write, ifid_flush, idex_bubble, redirect_en, mul_busy}
  } vec_t;

  localparam logic [5:0] ORun   = 6'b110000;
  localparam logic [5:0] OStall = 6'b000100;
  localparam logic [5:0] OTake  = 6'b111010;
  localparam logic [5:0] OBusy  = 6'b000101;

  logic        Clk = 1'b0;
  logic        rst = 1'b0;
  in_t         cur;
  logic        pc_write, ifid_write, ifid_flush, idex_bubble, redirect_en, mul_busy;
  logic [15:0] stall_cycles;
  logic [5:0]  outs;

  int checks = 0;
  int failures = 0;
  int m_freeze = 0;
  int m_stall = 0;

  always #5 Clk = ~Clk;

  assign outs = {pc_write, ifid_write, ifid_flush, idex_bubble, redirect_en, mul_busy};

  hazard_stall_controller #(
    .MUL_LATENCY(MulLat),
    .REG_ADDR_W (AW)
  ) dut (
    .Clk         (Clk),
    .Reset       (rst),
    .id_valid    (cur.valid),
    .id_rs       (cur.rs),
    .id_rt       (cur.rt),
    .id_uses_rt  (cur.uses_rt),
    .id_is_branch(cur.br),
    .id_take     (cur.take),
    .id_mul      (cur.mul),
    .ex_RegWrite (cur.ex_rw),
    .ex_MemRead  (cur.ex_mr),
    .ex_dst      (cur.ex_dst),
    .mem_MemRead (cur.mem_mr),
    .mem_dst     (cur.mem_dst),
    .pc_write    (pc_write),
    .ifid_write  (ifid_write),
    .ifid_flush  (ifid_flush),
    .idex_bubble (idex_bubble),
    .redirect_en (redirect_en),
    .mul_busy    (mul_busy),
    .stall_cycles(stall_cycles)
  );

  function automatic in_t mk(input logic valid, input int rs, input int rt, input logic uses_rt,
                             input logic br, input logic take, input logic mul, input logic ex_rw,
                             input logic ex_mr, input int ex_dst, input logic mem_mr,
                             input int mem_dst);
    in_t v;
    v.valid = valid;   v.rs = AW'(rs);     v.rt = AW'(rt);         v.uses_rt = uses_rt;
    v.br = br;         v.take = take;      v.mul = mul;            v.ex_rw = ex_rw;
    v.ex_mr = ex_mr;   v.ex_dst = AW'(ex_dst); v.mem_mr = mem_mr;  v.mem_dst = AW'(mem_dst);
    return v;
  endfunction

  function automatic in_t idle();
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  // Does the ID instruction read register d (nonzero)?
  function automatic bit reads(input in_t v, input logic [AW-1:0] d);
    if (d == 0) return 0;
    return (v.rs == d) || (v.uses_rt && v.rt == d);
  endfunction

  function automatic bit hazard(input in_t v);
    if (!v.valid) return 0;
    if (v.ex_mr && reads(v, v.ex_dst)) return 1;
    if (v.br && v.ex_rw && reads(v, v.ex_dst)) return 1;
    if (v.br && v.mem_mr && reads(v, v.mem_dst)) return 1;
    return 0;
  endfunction

  function automatic logic [5:0] model_out(input in_t v, input logic rst_n, input int freeze);
    if (!rst_n) return ORun;
    if (freeze > 0) return OBusy;
    if (hazard(v)) return OStall;
    if (v.valid && v.take) return OTake;
    return ORun;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One clock cycle: drive at the falling edge, sample 1ns later, then advance the model.
  task automatic step(input in_t v, input logic rst_v, input bit do_chk, input string name,
                      input bit use_hand, input logic [5:0] hand);
    logic [5:0]  exp;
    logic [15:0] exp_stall;
    @(negedge Clk);
    cur = v;
    rst = rst_v;
    #1;
    exp = model_out(v, rst_v, m_freeze);
`ifdef HAZARD_PERF_CNT_EN
    exp_stall = rst_v ? 16'(m_stall) : 16'h0000;
`else
    exp_stall = 16'h0000;
`endif
    if (do_chk) begin
      chk({name, "/outs"}, {10'h0, outs}, {10'h0, exp});
      chk({name, "/stall"}, stall_cycles, exp_stall);
      if (use_hand) chk({name, "/hand"}, {10'h0, outs}, {10'h0, hand});
    end
    if (!rst_v) begin
      m_freeze = 0;
      m_stall  = 0;
    end else begin
      if (!exp[5] && m_stall < 65535) m_stall++;
      if (m_freeze > 0) m_freeze--;
      else if (v.valid && v.mul && !hazard(v) && MulLat > 1) m_freeze = MulLat - 1;
    end
  endtask

  vec_t tbl[11];
  in_t  r;
  logic [15:0] exp_cnt;

  initial begin
    cur = idle();
    tbl[0]  = '{"load_use_rs",   mk(1, 8, 0, 0, 0, 0, 0, 1, 1, 8, 0, 0), OStall};
    tbl[1]  = '{"dst_zero",      mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0), ORun};
    tbl[2]  = '{"rt_unused",     mk(1, 3, 8, 0, 0, 0, 0, 1, 1, 8, 0, 0), ORun};
    tbl[3]  = '{"rt_used",       mk(1, 3, 8, 1, 0, 0, 0, 1, 1, 8, 0, 0), OStall};
    tbl[4]  = '{"invalid",       mk(0, 8, 8, 1, 1, 1, 1, 1, 1, 8, 1, 8), ORun};
    tbl[5]  = '{"br_ex_alu",     mk(1, 9, 0, 0, 1, 0, 0, 1, 0, 9, 0, 0), OStall};
    tbl[6]  = '{"alu_fwd",       mk(1, 9, 0, 0, 0, 0, 0, 1, 0, 9, 0, 0), ORun};
    tbl[7]  = '{"br_mem_load",   mk(1, 2, 9, 1, 1, 0, 0, 0, 0, 0, 1, 9), OStall};
    tbl[8]  = '{"take",          mk(1, 4, 5, 1, 1, 1, 0, 1, 0, 6, 1, 7), OTake};
    tbl[9]  = '{"take_hazard",   mk(1, 8, 0, 0, 0, 1, 0, 0, 1, 8, 0, 0), OStall};
    tbl[10] = '{"take_invalid",  mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0), ORun};

    step(idle(), 0, 1, "reset", 1, ORun);
    step(idle(), 1, 1, "release", 1, ORun);
    foreach (tbl[i]) step(tbl[i].in, 1, 1, tbl[i].name, 1, tbl[i].exp);
    step(idle(), 1, 1, "post_tbl", 1, ORun);

    // Branch after a load: stalls while the load is in EX and again in MEM.
    step(mk(1, 9, 0, 0, 1, 1, 0, 1, 1, 9, 0, 0), 1, 1, "bl_ex", 1, OStall);
    step(mk(1, 9, 0, 0, 1, 1, 0, 0, 0, 0, 1, 9), 1, 1, "bl_mem", 1, OStall);
    step(mk(1, 9, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0), 1, 1, "bl_go", 1, OTake);

    // Multiply freeze from a clean counter.
    step(idle(), 0, 1, "mul_rst", 1, ORun);
    step(idle(), 1, 1, "mul_rel", 1, ORun);
    step(mk(1, 1, 2, 1, 0, 0, 1, 0, 0, 0, 0, 0), 1, 1, "mul_entry", 1, ORun);
    for (int i = 0; i < 3; i++) step(mk(1, 8, 8, 1, 1, 1, 1, 1, 1, 8, 1, 8), 1, 1, "mul_busy", 1, OBusy);
    step(idle(), 1, 1, "mul_done", 1, ORun);
`ifdef HAZARD_PERF_CNT_EN
    exp_cnt = 16'd3;
`else
    exp_cnt = 16'd0;
`endif
    chk("mul_stall_cnt", stall_cycles, exp_cnt);

    // Multiply entry coinciding with a taken branch.
    step(mk(1, 1, 2, 1, 1, 1, 1, 0, 0, 0, 0, 0), 1, 1, "mul_take", 1, OTake);
    for (int i = 0; i < 3; i++) step(idle(), 1, 1, "mul_take_busy", 1, OBusy);
    step(idle(), 1, 1, "mul_take_done", 1, ORun);

    // Reset in the second freeze cycle.
    step(mk(1, 1, 2, 1, 0, 0, 1, 0, 0, 0, 0, 0), 1, 1, "rm_entry", 1, ORun);
    step(idle(), 1, 1, "rm_busy1", 1, OBusy);
    step(mk(1, 1, 2, 1, 0, 1, 1, 0, 1, 1, 0, 0), 0, 1, "rm_reset", 1, ORun);
    chk("rm_reset_cnt", stall_cycles, 16'h0000);
    step(idle(), 1, 1, "rm_rel", 1, ORun);
    step(idle(), 1, 1, "rm_run", 1, ORun);

    // Random traffic with small register numbers to provoke hits.
    for (int n = 0; n < 3000; n++) begin
      r = mk($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
             1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 7) == 0, 1'($urandom),
             1'($urandom), $urandom_range(0, 3), 1'($urandom), $urandom_range(0, 3));
      step(r, $urandom_range(0, 63) != 0, 1, "rand", 0, ORun);
    end

    // Counter saturation.
    step(idle(), 0, 1, "sat_rst", 1, ORun);
    for (int n = 0; n < 70000; n++) step(tbl[0].in, 1, 0, "sat", 0, ORun);
`ifdef HAZARD_PERF_CNT_EN
    exp_cnt = 16'hFFFF;
`else
    exp_cnt = 16'h0000;
`endif
    step(tbl[0].in, 1, 1, "sat_a", 1, OStall);
    chk("sat_value", stall_cycles, exp_cnt);
    step(tbl[0].in, 1, 1, "sat_b", 1, OStall);
    chk("sat_hold", stall_cycles, exp_cnt);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Pipeline sequencing controller for the decode stage of the 5-stage MIPS core.
- Decides each cycle whether PC and IF/ID advance, whether ID/EX receives a bubble, and whether a taken branch or jump redirects fetch and squashes IF/ID.
- Covers load-use hazards, hazards on operands of branches resolved in ID, and a fixed-latency multi-cycle multiply freeze.
- Sits beside the decode phase; consumes Controller/Comparator results plus EX/MEM pipeline-register fields.

Parameters:
- MUL_LATENCY, 4, total EX cycles of a multiply (legal range 1..15); pipeline freezes MUL_LATENCY-1 cycles.
- REG_ADDR_W, 5, register address width.

Ports:
- Clk  input  1  clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- id_valid  input  1  IF/ID holds a real instruction.
- id_rs  input  REG_ADDR_W  instr[25:21].
- id_rt  input  REG_ADDR_W  instr[20:16].
- id_uses_rt  input  1  ID instruction reads rt as a source.
- id_is_branch  input  1  Branch from Controller.
- id_take  input  1  Controller/Comparator say branch taken, or Jump, or JumpRegister.
- id_mul  input  1  ID instruction is a multiply.
- ex_RegWrite  input  1  ID/EX RegWrite.
- ex_MemRead  input  1  ID/EX MemRead.
- ex_dst  input  REG_ADDR_W  ID/EX destination register after the RegDst mux.
- mem_MemRead  input  1  EX/MEM MemRead.
- mem_dst  input  REG_ADDR_W  EX/MEM destination register.
- pc_write  output  1  PC register enable.
- ifid_write  output  1  IF/ID enable.
- ifid_flush  output  1  IF/ID loads a NOP.
- idex_bubble  output  1  ID/EX loads zeroed control signals.
- redirect_en  output  1  PC mux may select the branch/jump target.
- mul_busy  output  1  freeze in progress.
- stall_cycles  output  16  performance counter.

Behaviour:
- Reset: state RUN, mul counter 0.
- Outputs during reset: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0, redirect_en=0, mul_busy=0, stall_cycles=0.
- Outputs are combinational (Mealy) from state and inputs, so a hazard acts in the same cycle it is detected.
- match(a,d) = (d != 0) & (a == d). Register $0 never causes a hazard.
- src_hit(d) = match(id_rs,d) | (id_uses_rt & match(id_rt,d)).
- load_use = id_valid & ex_MemRead & src_hit(ex_dst).
- br_ex = id_valid & id_is_branch & ex_RegWrite & src_hit(ex_dst).
- br_mem = id_valid & id_is_branch & mem_MemRead & src_hit(mem_dst).
- data_stall = load_use | br_ex | br_mem.
- States: RUN, MUL_WAIT.
- RUN with data_stall:
  - pc_write=0, ifid_write=0, idex_bubble=1, redirect_en=0, ifid_flush=0.
  - Stay RUN; the condition is re-evaluated next cycle, so a branch after a load stalls 2 cycles.
- RUN, no data_stall, id_valid & id_take:
  - redirect_en=1, ifid_flush=1, pc_write=1, idex_bubble=0.
- RUN, no data_stall, id_valid & id_mul & MUL_LATENCY>1:
  - The multiply passes to EX normally.
  - Load counter with MUL_LATENCY-1 and go to MUL_WAIT.
  - A take in the same cycle is legal and applied normally.
- MUL_WAIT:
  - pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0, redirect_en=0, mul_busy=1.
  - Counter decrements each cycle; when counter==1, next state is RUN.
  - All ID inputs are ignored; the held ID instruction is re-evaluated in RUN.
- Priority: Reset > MUL_WAIT > data_stall > take > mul entry.
- stall_cycles increments on every cycle with pc_write=0 and saturates at 16'hFFFF.
- Reset asserted mid-MUL_WAIT or mid-stall: immediate return to RUN, counter cleared, reset output values.
- id_valid=0: no stall, no redirect, no MUL_WAIT entry.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined: stall_cycles counter implemented as above.
- Undefined: no counter register; stall_cycles is tied to 16'h0000; all other behaviour is identical.

Test Plan:
- ex_MemRead=1, ex_dst=8, id_rs=8, id_valid=1 -> one cycle of pc_write=0, ifid_write=0, idex_bubble=1; next cycle (EX bubble) pc_write=1.
- Same stimulus with ex_dst=0 -> no stall.
- Same stimulus with id_rt=8 and id_uses_rt=0 -> no stall.
- Branch on rs=9, ex_MemRead=1, ex_dst=9, then load moves to MEM (mem_dst=9) -> 2 stall cycles with redirect_en=0; third cycle with id_take=1 -> redirect_en=1, ifid_flush=1.
- id_mul=1, MUL_LATENCY=4 -> mul_busy=1 for exactly 3 cycles with pc_write=0; id_take during those cycles gives redirect_en=0; stall_cycles reads 3 afterwards (macro defined).
- Reset driven low during MUL_WAIT cycle 2 -> outputs return to reset values immediately; after release, state is RUN and mul_busy=0.
- Drive 70000 stall cycles -> stall_cycles=16'hFFFF and holds (macro defined); 0 when undefined.
